inst_fetch: RTL and testbench

//  Fetch stage plus IF/ID register. Generates the fetch PC and runs one outstanding req/ack on the instruction bus.

---
 rtl/inst_fetch_pkg.sv | 24 ++
 rtl/inst_fetch_if_hold_buf.sv | 29 ++
 rtl/inst_fetch.sv | 166 ++++++++++++++++
 tb/tb_inst_fetch.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage and its IF/ID register.
package inst_fetch_pkg;

  typedef logic        bit_t;
  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam inst_addr_t PC_RESET_ADDR = 32'hBFC0_0000;
  localparam inst_t      NOP_INST_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DRAIN} fetch_state_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
    bit_t       valid;
    bit_t       adel;
  } ifid_t;

  function automatic bit_t is_misaligned(input inst_addr_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/inst_fetch_if_hold_buf.sv
// One-entry pc/inst/adel buffer that catches an ack arriving while decode is stalled.
module if_hold_buf
  import inst_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic       clr,
  input  inst_addr_t wr_pc,
  input  inst_t      wr_inst,
  input  logic       wr_adel,
  output logic       full,
  output inst_addr_t rd_pc,
  output inst_t      rd_inst,
  output logic       rd_adel
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       full <= 1'b0;
    else if (clr)   full <= 1'b0;
    else if (wr_en) full <= 1'b1;
  end

  // NOTE: payload registers carry no reset; full qualifies every read of them.
  always_ff @(posedge clk) begin
    if (wr_en) {rd_pc, rd_inst, rd_adel} <= {wr_pc, wr_inst, wr_adel};
  end

endmodule

// File: rtl/inst_fetch.sv
// Fetch stage with IF/ID register: one outstanding ibus request, delay-slot branch redirect,
// exception flush with drain of an abandoned request, and a one-entry stall buffer.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter inst_addr_t RESET_PC = PC_RESET_ADDR,
  parameter inst_t      NOP_INST = NOP_INST_WORD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        ibus_req_o,
  output logic [31:0] ibus_addr_o,
  input  logic        ibus_ack_i,
  input  logic [31:0] ibus_rdata_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        valid_o,
  output logic        adel_o
);

  fetch_state_t state, state_d;
  inst_addr_t   fetch_pc, fetch_pc_d;
  inst_addr_t   pend_target, pend_target_d;
  inst_addr_t   drain_addr, drain_addr_d;
  logic         pend, pend_d;
  ifid_t        ifid, ifid_d;

  logic         hold_wr, hold_clr, hold_full, hold_adel;
  inst_addr_t   hold_pc;
  inst_t        hold_inst;

  logic         misaligned, ack_take, take_branch;
  inst_addr_t   seq_pc;
  ifid_t        bubble;

  assign misaligned  = is_misaligned(fetch_pc);
  assign ack_take    = (state == S_REQ) && !misaligned && ibus_ack_i;
  assign take_branch = branch_flag_i && !stall_i;
  assign seq_pc      = take_branch ? branch_target_i :
                       pend        ? pend_target     : fetch_pc + 32'd4;
  assign bubble      = '{pc: ifid.pc, inst: NOP_INST, valid: 1'b0, adel: 1'b0};

  assign ibus_req_o  = ((state == S_REQ) && !misaligned) || (state == S_DRAIN);
  assign ibus_addr_o = (state == S_DRAIN) ? drain_addr : fetch_pc;
  assign pc_o        = ifid.pc;
  assign inst_o      = ifid.inst;
  assign valid_o     = ifid.valid;
  assign adel_o      = ifid.adel;

  if_hold_buf u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .clr     (hold_clr),
    .wr_pc   (fetch_pc),
    .wr_inst (ibus_rdata_i),
    .wr_adel (1'b0),
    .full    (hold_full),
    .rd_pc   (hold_pc),
    .rd_inst (hold_inst),
    .rd_adel (hold_adel)
  );

  // NOTE: every signal gets its default before the case so no path leaves one unassigned (no latches).
  always_comb begin
    state_d       = state;
    fetch_pc_d    = fetch_pc;
    pend_d        = pend;
    pend_target_d = pend_target;
    drain_addr_d  = drain_addr;
    ifid_d        = ifid;
    hold_wr       = 1'b0;
    hold_clr      = 1'b0;

    if (flush_i) begin
      fetch_pc_d   = flush_pc_i;
      pend_d       = 1'b0;
      hold_clr     = 1'b0 | 1'b1;
      ifid_d.valid = 1'b0;
      ifid_d.adel  = 1'b0;
      ifid_d.inst  = NOP_INST;
      if (state == S_DRAIN) begin
        state_d = ibus_ack_i ? S_REQ : S_DRAIN;
      end else if ((state == S_REQ) && !misaligned && !ibus_ack_i) begin
        // The bus still owes an ack for the old address; swallow it before refetching.
        drain_addr_d = fetch_pc;
        state_d      = S_DRAIN;
      end else begin
        state_d = S_REQ;
      end
    end else begin
      unique case (state)
        S_IDLE: begin
          state_d = S_REQ;
          if (!stall_i) ifid_d = bubble;
        end
        S_REQ: begin
          if (misaligned) begin
            if (!stall_i) begin
              ifid_d  = '{pc: fetch_pc, inst: NOP_INST, valid: 1'b1, adel: 1'b1};
              state_d = S_HOLD;
            end
          end else if (ibus_ack_i) begin
            fetch_pc_d = seq_pc;
            pend_d     = 1'b0;
            if (!stall_i) begin
              ifid_d = '{pc: fetch_pc, inst: ibus_rdata_i, valid: 1'b1, adel: 1'b0};
            end else begin
              hold_wr = 1'b1;
              state_d = S_HOLD;
            end
          end else begin
            // Delay slot still in flight: remember the target until its ack.
            if (take_branch) begin
              pend_d        = 1'b1;
              pend_target_d = branch_target_i;
            end
            if (!stall_i) ifid_d = bubble;
          end
        end
        S_HOLD: begin
          // Empty hold here means a misaligned fetch is parked waiting for a flush.
          if (hold_full && !stall_i) begin
            ifid_d   = '{pc: hold_pc, inst: hold_inst, valid: 1'b1, adel: hold_adel};
            hold_clr = 1'b1;
            state_d  = S_REQ;
            if (branch_flag_i) fetch_pc_d = branch_target_i;
          end
        end
        S_DRAIN: begin
          if (ibus_ack_i) state_d = S_REQ;
          if (!stall_i) ifid_d = bubble;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_d;
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc    <= RESET_PC;
      pend        <= 1'b0;
      pend_target <= RESET_PC;
      drain_addr  <= RESET_PC;
      ifid        <= '{pc: RESET_PC, inst: NOP_INST, valid: 1'b0, adel: 1'b0};
    end else begin
      fetch_pc    <= fetch_pc_d;
      pend        <= pend_d;
      pend_target <= pend_target_d;
      drain_addr  <= drain_addr_d;
      ifid        <= ifid_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: stream, delay-slot branch, stall buffer, flush drain,
// misaligned park and asynchronous reset in the middle of a drain.
module tb_inst_fetch;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] pc;
    logic [31:0] inst;
    logic        valid;
    logic        adel;
  } view_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        flush_i = 1'b0;
  logic [31:0] flush_pc_i = 32'h0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        ibus_req_o;
  logic [31:0] ibus_addr_o;
  logic        ibus_ack_i;
  logic [31:0] ibus_rdata_i;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        valid_o;
  logic        adel_o;

  int vectors    = 0;
  int miscompares = 0;
  int ack_delay  = 0;
  int wait_cnt;
  view_t obs, exp;

  inst_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .flush_i         (flush_i),
    .flush_pc_i      (flush_pc_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .ibus_req_o      (ibus_req_o),
    .ibus_addr_o     (ibus_addr_o),
    .ibus_ack_i      (ibus_ack_i),
    .ibus_rdata_i    (ibus_rdata_i),
    .pc_o            (pc_o),
    .inst_o          (inst_o),
    .valid_o         (valid_o),
    .adel_o          (adel_o)
  );

  always #5 clk = ~clk;

  // Instruction memory: every word reads as the inverted address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return ~a;
  endfunction

  // Bus slave acks once a request has waited ack_delay cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst)                          wait_cnt <= 0;
    else if (ibus_req_o && !ibus_ack_i) wait_cnt <= wait_cnt + 1;
    else                               wait_cnt <= 0;
  end
  assign ibus_ack_i   = ibus_req_o && (wait_cnt >= ack_delay);
  assign ibus_rdata_i = imem(ibus_addr_o);
  assign obs = {ibus_req_o, ibus_addr_o, pc_o, inst_o, valid_o, adel_o};

  task automatic test_reset();
    repeat (2) @(negedge clk);
    exp = '{1'b0, 32'hBFC0_0000, 32'hBFC0_0000, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL reset_values: got %p want %p", obs, exp); end
    rst = 1'b1;
  endtask

  task automatic test_stream();
    logic [31:0] a;
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0000, 32'hBFC0_0000, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL stream_first_req: got %p want %p", obs, exp); end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      a   = 32'hBFC0_0000 + 32'(4 * (k - 1));
      exp = '{1'b1, a + 32'd4, a, imem(a), 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL stream k=%0d: got %p want %p", k, obs, exp); end
    end
  endtask

  task automatic test_branch_delay_slot();
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0014, 32'hBFC0_0010, imem(32'hBFC0_0010), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL branch_in_ifid: got %p want %p", obs, exp); end
    ack_delay = 2; branch_flag_i = 1'b1; branch_target_i = 32'h8000_0000;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      branch_flag_i = 1'b0;
      exp = '{1'b1, 32'hBFC0_0014, 32'hBFC0_0010, 32'h0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL delay_slot_wait %0d: got %p want %p", k, obs, exp); end
    end
    @(negedge clk);
    exp = '{1'b1, 32'h8000_0000, 32'hBFC0_0014, imem(32'hBFC0_0014), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL delay_slot_then_target: got %p want %p", obs, exp); end
    ack_delay = 0;
    @(negedge clk);
    exp = '{1'b1, 32'h8000_0004, 32'h8000_0000, imem(32'h8000_0000), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL target_in_ifid: got %p want %p", obs, exp); end
  endtask

  task automatic test_stall_hold();
    stall_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = '{1'b0, 32'h8000_0008, 32'h8000_0000, imem(32'h8000_0000), 1'b1, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL stall_frozen %0d: got %p want %p", k, obs, exp); end
    end
    stall_i = 1'b0;
    @(negedge clk);
    exp = '{1'b1, 32'h8000_0008, 32'h8000_0004, imem(32'h8000_0004), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL hold_release: got %p want %p", obs, exp); end
    @(negedge clk);
    exp = '{1'b1, 32'h8000_000C, 32'h8000_0008, imem(32'h8000_0008), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL resume_after_hold: got %p want %p", obs, exp); end
  endtask

  task automatic test_flush_drain();
    ack_delay = 3; flush_i = 1'b1; flush_pc_i = 32'hBFC0_0380;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      flush_i = 1'b0;
      exp = '{1'b1, 32'h8000_000C, 32'h8000_0008, 32'h0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL drain_old_addr %0d: got %p want %p", k, obs, exp); end
    end
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0380, 32'h8000_0008, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL flush_refetch: got %p want %p", obs, exp); end
    ack_delay = 0;
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0384, 32'hBFC0_0380, imem(32'hBFC0_0380), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL flush_target_in_ifid: got %p want %p", obs, exp); end
  endtask

  task automatic test_misaligned();
    flush_i = 1'b1; flush_pc_i = 32'h8000_0002;
    @(negedge clk);
    flush_i = 1'b0;
    exp = '{1'b0, 32'h8000_0002, 32'hBFC0_0380, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL misaligned_no_req: got %p want %p", obs, exp); end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp = '{1'b0, 32'h8000_0002, 32'h8000_0002, 32'h0, 1'b1, 1'b1};
      vectors++;
      if (obs !== exp) begin miscompares++; $display("FAIL adel_parked %0d: got %p want %p", k, obs, exp); end
    end
  endtask

  task automatic test_reset_in_drain();
    ack_delay = 100; flush_i = 1'b1; flush_pc_i = 32'hBFC0_0100;
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0100, 32'h8000_0002, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL unpark_refetch: got %p want %p", obs, exp); end
    flush_pc_i = 32'hBFC0_0200;
    @(negedge clk);
    flush_i = 1'b0;
    exp = '{1'b1, 32'hBFC0_0100, 32'h8000_0002, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL drain_before_reset: got %p want %p", obs, exp); end
    #2 rst = 1'b0;
    #1;
    exp = '{1'b0, 32'hBFC0_0000, 32'hBFC0_0000, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL async_reset: got %p want %p", obs, exp); end
    @(negedge clk);
    rst = 1'b1; ack_delay = 0;
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0000, 32'hBFC0_0000, 32'h0, 1'b0, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL refetch_after_reset: got %p want %p", obs, exp); end
    @(negedge clk);
    exp = '{1'b1, 32'hBFC0_0004, 32'hBFC0_0000, imem(32'hBFC0_0000), 1'b1, 1'b0};
    vectors++;
    if (obs !== exp) begin miscompares++; $display("FAIL first_inst_after_reset: got %p want %p", obs, exp); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_branch_delay_slot();
    test_stall_hold();
    test_flush_drain();
    test_misaligned();
    test_reset_in_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
